// File: rtl/pipeline_debug_unit.sv
// Host-side debug controller for the 5-stage MIPS pipeline, driven by UART bytes.
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-high reset
//   i_rx_data, i_rx_done           received byte and its 1-cycle strobe
//   i_tx_done                      UART finished sending the current byte
//   o_tx_start, o_tx_data          1-cycle send strobe and byte to send
//   i_pc, i_mem, i_reg             pipeline readback words (i_mem/i_reg at o_debug_addr)
//   i_halt                         pipeline has retired HALT
//   o_write, o_instruction         instruction-memory load strobe and word
//   o_enable                       pipeline clock enable
//   o_debug_addr                   register/memory readback index
//   o_busy                         controller is not idle
module pipeline_debug_unit #(
    parameter int unsigned INST_SZ = 32,
    parameter int unsigned PC_SZ   = 32,
    parameter int unsigned REG_SZ  = 5,
    parameter int unsigned BYTE_SZ = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [BYTE_SZ-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [BYTE_SZ-1:0] o_tx_data,
    input  logic [PC_SZ-1:0]   i_pc,
    input  logic [INST_SZ-1:0] i_mem,
    input  logic [INST_SZ-1:0] i_reg,
    input  logic               i_halt,
    output logic               o_write,
    output logic [INST_SZ-1:0] o_instruction,
    output logic               o_enable,
    output logic [REG_SZ-1:0]  o_debug_addr,
    output logic               o_busy
);

    localparam int unsigned BPW       = INST_SZ / BYTE_SZ;
    localparam int unsigned BIDX_W    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned NREG      = 2 ** REG_SZ;
    localparam int unsigned WIDX_W    = REG_SZ + 2;
    localparam int unsigned LAST_WORD = 2 * NREG;
    localparam int unsigned PAD_W     = INST_SZ - BYTE_SZ;

    localparam logic [BYTE_SZ-1:0] CMD_LOAD  = BYTE_SZ'(8'h4C);
    localparam logic [BYTE_SZ-1:0] CMD_RUN   = BYTE_SZ'(8'h52);
    localparam logic [BYTE_SZ-1:0] CMD_STEP  = BYTE_SZ'(8'h53);
    localparam logic [BYTE_SZ-1:0] CMD_DUMP  = BYTE_SZ'(8'h44);
    localparam logic [BYTE_SZ-1:0] REPLY_ACK = BYTE_SZ'(8'h4B);
    localparam logic [BYTE_SZ-1:0] REPLY_UNK = BYTE_SZ'(8'h3F);

    typedef enum logic [3:0] {
        IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP,
        DP_ADDR, DP_SETTLE, DP_LATCH, TX_SEND, TX_WAIT, ACK
    } state_t;

    state_t              r_state;
    logic [BIDX_W-1:0]   r_byte_idx;   // byte within current word (load and dump)
    logic [WIDX_W-1:0]   r_word_idx;   // dump word: 0 = PC, 1..NREG = regs, then mems
    logic [BYTE_SZ-1:0]  r_words_left;
    logic [INST_SZ-1:0]  r_shift;      // outgoing word, MSB byte first
    logic                r_dumping;    // TX completion continues the dump rather than idling

    // Single-process controller; strobes default low every cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_byte_idx    <= '0;
            r_word_idx    <= '0;
            r_words_left  <= '0;
            r_shift       <= '0;
            r_dumping     <= 1'b0;
            o_tx_start    <= 1'b0;
            o_tx_data     <= '0;
            o_write       <= 1'b0;
            o_instruction <= '0;
            o_enable      <= 1'b0;
            o_debug_addr  <= '0;
            o_busy        <= 1'b0;
        end else begin
            o_write    <= 1'b0;
            o_tx_start <= 1'b0;
            o_enable   <= 1'b0;

            case (r_state)
                IDLE: begin
                    o_debug_addr <= '0;
                    r_byte_idx   <= '0;
                    r_word_idx   <= '0;
                    r_dumping    <= 1'b0;
                    if (i_rx_done) begin
                        o_busy <= 1'b1;
                        case (i_rx_data)
                            CMD_LOAD: r_state <= LD_CNT;
                            CMD_RUN:  r_state <= RUN;
                            CMD_STEP: r_state <= STEP;
                            CMD_DUMP: r_state <= DP_ADDR;
                            default: begin
                                r_shift <= {REPLY_UNK, {PAD_W{1'b0}}};
                                r_state <= TX_SEND;
                            end
                        endcase
                    end
                end

                LD_CNT: begin
                    if (i_rx_done) begin
                        r_words_left <= i_rx_data;
                        r_state      <= (i_rx_data == '0) ? ACK : LD_BYTE;
                    end
                end

                LD_BYTE: begin
                    if (i_rx_done) begin
                        o_instruction <= {o_instruction[INST_SZ-BYTE_SZ-1:0], i_rx_data};
                        r_byte_idx    <= r_byte_idx + BIDX_W'(1);
                        if (r_byte_idx == BIDX_W'(BPW - 1)) begin
                            r_byte_idx <= '0;
                            o_write    <= 1'b1;
                            r_state    <= LD_WR;
                        end
                    end
                end

                // o_write is high during this cycle
                LD_WR: begin
                    r_words_left <= r_words_left - BYTE_SZ'(1);
                    r_state      <= (r_words_left == BYTE_SZ'(1)) ? ACK : LD_BYTE;
                end

                ACK: begin
                    r_shift <= {REPLY_ACK, {PAD_W{1'b0}}};
                    r_state <= TX_SEND;
                end

                RUN: begin
                    if (i_halt) r_state <= DP_ADDR;
                    else        o_enable <= 1'b1;
                end

                // The single enable cycle overlaps DP_ADDR; readback happens later.
                STEP: begin
                    if (!i_halt) o_enable <= 1'b1;
                    r_state <= DP_ADDR;
                end

                // Word index 1..2*NREG maps onto address 0..NREG-1 twice (regs, then mems).
                DP_ADDR: begin
                    r_dumping    <= 1'b1;
                    o_debug_addr <= (r_word_idx == '0) ? '0 : REG_SZ'(r_word_idx - WIDX_W'(1));
                    r_state      <= DP_SETTLE;
                end

                DP_SETTLE: r_state <= DP_LATCH;

                DP_LATCH: begin
                    if (r_word_idx == '0)                   r_shift <= INST_SZ'(i_pc);
                    else if (r_word_idx <= WIDX_W'(NREG))   r_shift <= i_reg;
                    else                                    r_shift <= i_mem;
                    r_state <= TX_SEND;
                end

                TX_SEND: begin
                    o_tx_start <= 1'b1;
                    o_tx_data  <= r_shift[INST_SZ-1 -: BYTE_SZ];
                    r_shift    <= r_shift << BYTE_SZ;
                    r_state    <= TX_WAIT;
                end

                TX_WAIT: begin
                    if (i_tx_done) begin
                        if (r_dumping && (r_byte_idx != BIDX_W'(BPW - 1))) begin
                            r_byte_idx <= r_byte_idx + BIDX_W'(1);
                            r_state    <= TX_SEND;
                        end else if (r_dumping && (r_word_idx != WIDX_W'(LAST_WORD))) begin
                            r_byte_idx <= '0;
                            r_word_idx <= r_word_idx + WIDX_W'(1);
                            r_state    <= DP_ADDR;
                        end else begin
                            o_busy       <= 1'b0;
                            o_debug_addr <= '0;
                            r_state      <= IDLE;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_debug_unit.sv
// Self-checking bench for pipeline_debug_unit: fixed vector table, hand sequences
// (slow UART, reset mid-load) and randomized commands checked against a transaction model.
module tb_pipeline_debug_unit;

    localparam int BUDGET = 40000;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_done;
    logic        i_tx_done = 1'b0;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic [31:0] i_pc;
    logic [31:0] i_mem;
    logic [31:0] i_reg;
    logic        i_halt = 1'b0;
    logic        o_write;
    logic [31:0] o_instruction;
    logic        o_enable;
    logic [4:0]  o_debug_addr;
    logic        o_busy;

    pipeline_debug_unit dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .i_tx_done(i_tx_done),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .i_pc(i_pc), .i_mem(i_mem), .i_reg(i_reg), .i_halt(i_halt),
        .o_write(o_write), .o_instruction(o_instruction), .o_enable(o_enable),
        .o_debug_addr(o_debug_addr), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Pipeline side: readback is only valid once the address has been stable a cycle.
    logic [31:0] reg_arr [32];
    logic [31:0] mem_arr [32];
    logic [31:0] pc_val;
    logic [4:0]  prev_addr = 5'd0;
    always @(posedge i_clk) prev_addr <= o_debug_addr;
    assign i_reg = (o_debug_addr == prev_addr) ? reg_arr[o_debug_addr] : 32'hDEADBEEF;
    assign i_mem = (o_debug_addr == prev_addr) ? mem_arr[o_debug_addr] : 32'hDEADBEEF;
    assign i_pc  = pc_val;

    // Monitor / UART-TX responder / halt generator
    logic [7:0]  tx_q [$];
    logic [31:0] wr_q [$];
    int          en_cnt = 0;
    int          proto_err = 0;
    int          tx_delay = 1;
    int          tx_cnt = 0;
    bit          tx_busy = 1'b0;
    logic [7:0]  tx_hold = 8'h00;
    bit          halt_force = 1'b0;
    bit          halt_armed = 1'b0;
    int          halt_at = 0;

    always @(negedge i_clk) begin
        if (i_tx_done) begin
            i_tx_done = 1'b0;
            tx_busy   = 1'b0;
        end
        if (o_tx_start === 1'b1) begin
            if (tx_busy) begin
                proto_err++;
                $display("FAIL tx_start_overlap: got o_tx_start=1 while byte outstanding, required 0");
            end
            tx_q.push_back(o_tx_data);
            tx_hold = o_tx_data;
            tx_busy = 1'b1;
            tx_cnt  = tx_delay;
        end else if (tx_busy) begin
            if (o_tx_data !== tx_hold) begin
                proto_err++;
                $display("FAIL tx_data_stable: got %h required %h", o_tx_data, tx_hold);
            end
            if (tx_cnt == 0) i_tx_done = 1'b1;
            else             tx_cnt--;
        end
        if (o_write === 1'b1)  wr_q.push_back(o_instruction);
        if (o_enable === 1'b1) en_cnt++;
        i_halt = halt_force || (halt_armed && (en_cnt >= halt_at));
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
        repeat (3) @(negedge i_clk);
    endtask

    task automatic wait_idle();
        int c = 0;
        while (o_busy !== 1'b0 && c < BUDGET) begin
            @(negedge i_clk);
            c++;
        end
        if (c >= BUDGET) begin
            check("idle_timeout", 32'(o_busy), 32'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
        repeat (3) @(negedge i_clk);
    endtask

    logic [31:0] ld_words [4];
    int tx_base, wr_base, en_base, pe_base;

    // Issue one host command (plus its load payload) and wait for completion.
    task automatic run_txn(input logic [7:0] cmd, input int n, input bit halt_pre,
                           input int run_len, input bit stray);
        tx_base    = tx_q.size();
        wr_base    = wr_q.size();
        en_base    = en_cnt;
        pe_base    = proto_err;
        halt_force = halt_pre;
        if (cmd == 8'h52 && !halt_pre) begin
            halt_at    = en_cnt + run_len;
            halt_armed = 1'b1;
        end
        send_byte(cmd);
        if (cmd == 8'h4C) begin
            send_byte(8'(n));
            for (int w = 0; w < n; w++)
                for (int b = 0; b < 4; b++)
                    send_byte(8'(ld_words[w] >> (24 - 8 * b)));
        end
        if (stray) send_byte(8'h58);
        wait_idle();
        halt_armed = 1'b0;
    endtask

    function automatic logic [7:0] tx_at(input int k);
        if (tx_base + k < tx_q.size()) return tx_q[tx_base + k];
        return 8'hxx;
    endfunction

    // Transaction model: expected host byte stream, write count and enable cycles.
    logic [7:0] exp_q [$];
    int exp_wr, exp_en;

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(8'(w >> (24 - 8 * b)));
    endtask

    task automatic build_exp(input logic [7:0] cmd, input int n, input bit halt_pre, input int run_len);
        exp_q.delete();
        exp_wr = 0;
        exp_en = 0;
        if (cmd == 8'h4C) begin
            exp_q.push_back(8'h4B);
            exp_wr = n;
        end else if (cmd == 8'h52 || cmd == 8'h53 || cmd == 8'h44) begin
            if (cmd == 8'h52 && !halt_pre) exp_en = run_len;
            if (cmd == 8'h53 && !halt_pre) exp_en = 1;
            push_word(pc_val);
            for (int i = 0; i < 32; i++) push_word(reg_arr[i]);
            for (int i = 0; i < 32; i++) push_word(mem_arr[i]);
        end else begin
            exp_q.push_back(8'h3F);
        end
    endtask

    task automatic compare_model(input string tag);
        int got_len = tx_q.size() - tx_base;
        check({tag, " tx_count"}, 32'(got_len), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_len; k++) begin
            check($sformatf("%s tx_byte_%0d", tag, k), 32'(tx_at(k)), 32'(exp_q[k]));
            if (tx_at(k) !== exp_q[k]) break;
        end
        check({tag, " write_count"}, 32'(wr_q.size() - wr_base), 32'(exp_wr));
        for (int i = 0; i < exp_wr && (wr_base + i) < wr_q.size(); i++)
            check($sformatf("%s write_word_%0d", tag, i), wr_q[wr_base + i], ld_words[i]);
        check({tag, " enable_cycles"}, 32'(en_cnt - en_base), 32'(exp_en));
        check({tag, " tx_protocol"}, 32'(proto_err - pe_base), 32'd0);
        check({tag, " busy_after"}, 32'(o_busy), 32'd0);
        check({tag, " addr_after"}, 32'(o_debug_addr), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " o_busy"},        32'(o_busy),        32'd0);
        check({tag, " o_write"},       32'(o_write),       32'd0);
        check({tag, " o_tx_start"},    32'(o_tx_start),    32'd0);
        check({tag, " o_tx_data"},     32'(o_tx_data),     32'd0);
        check({tag, " o_enable"},      32'(o_enable),      32'd0);
        check({tag, " o_debug_addr"},  32'(o_debug_addr),  32'd0);
        check({tag, " o_instruction"}, o_instruction,      32'd0);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          halt;
        int          run_len;
        int          exp_len;
        logic [7:0]  exp_b0;
        logic [7:0]  exp_b3;
        logic [7:0]  exp_b39;
        int          exp_wr;
        int          exp_en;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{8'h4C, 2, 32'h20080005, 32'hFC000000, 1'b0, 0,   1, 8'h4B, 8'h00, 8'h00, 2, 0};
        vecs[1] = '{8'h53, 0, 32'h0, 32'h0, 1'b0, 0,             260, 8'h00, 8'h04, 8'h05, 0, 1};
        vecs[2] = '{8'h58, 0, 32'h0, 32'h0, 1'b0, 0,               1, 8'h3F, 8'h00, 8'h00, 0, 0};
        vecs[3] = '{8'h53, 0, 32'h0, 32'h0, 1'b1, 0,             260, 8'h00, 8'h04, 8'h05, 0, 0};
        vecs[4] = '{8'h44, 0, 32'h0, 32'h0, 1'b0, 0,             260, 8'h00, 8'h04, 8'h05, 0, 0};
        vecs[5] = '{8'h52, 0, 32'h0, 32'h0, 1'b0, 10,            260, 8'h00, 8'h04, 8'h05, 0, 10};
        vecs[6] = '{8'h4C, 0, 32'h0, 32'h0, 1'b0, 0,               1, 8'h4B, 8'h00, 8'h00, 0, 0};
        vecs[7] = '{8'h52, 0, 32'h0, 32'h0, 1'b1, 0,             260, 8'h00, 8'h04, 8'h05, 0, 0};

        i_reset   = 1'b1;
        i_rx_done = 1'b0;
        i_rx_data = 8'h00;
        pc_val    = 32'h00000004;
        for (int i = 0; i < 32; i++) begin
            reg_arr[i] = 32'h0;
            mem_arr[i] = 32'h0;
        end
        reg_arr[8] = 32'h00000005;
        for (int i = 0; i < 4; i++) ld_words[i] = 32'h0;

        repeat (3) @(negedge i_clk);
        check_outputs_zero("reset");
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);

        // Fixed vectors against hand-derived expectations
        for (int v = 0; v < 8; v++) begin
            ld_words[0] = vecs[v].w0;
            ld_words[1] = vecs[v].w1;
            run_txn(vecs[v].cmd, vecs[v].n, vecs[v].halt, vecs[v].run_len, 1'b0);
            check($sformatf("vec%0d tx_count", v), 32'(tx_q.size() - tx_base), 32'(vecs[v].exp_len));
            check($sformatf("vec%0d tx_byte0", v), 32'(tx_at(0)), 32'(vecs[v].exp_b0));
            if (vecs[v].exp_len > 39) begin
                check($sformatf("vec%0d tx_byte3", v),  32'(tx_at(3)),  32'(vecs[v].exp_b3));
                check($sformatf("vec%0d tx_byte39", v), 32'(tx_at(39)), 32'(vecs[v].exp_b39));
            end
            check($sformatf("vec%0d write_count", v), 32'(wr_q.size() - wr_base), 32'(vecs[v].exp_wr));
            if (vecs[v].exp_wr > 0 && wr_q.size() > wr_base + 1) begin
                check($sformatf("vec%0d write_word0", v), wr_q[wr_base],     vecs[v].w0);
                check($sformatf("vec%0d write_word1", v), wr_q[wr_base + 1], vecs[v].w1);
            end
            check($sformatf("vec%0d enable_cycles", v), 32'(en_cnt - en_base), 32'(vecs[v].exp_en));
            check($sformatf("vec%0d busy_after", v), 32'(o_busy), 32'd0);
        end

        // Slow UART: 50-cycle completion per byte during a full dump
        pc_val = $urandom();
        for (int i = 0; i < 32; i++) begin
            reg_arr[i] = $urandom();
            mem_arr[i] = $urandom();
        end
        tx_delay = 50;
        run_txn(8'h44, 0, 1'b0, 0, 1'b0);
        build_exp(8'h44, 0, 1'b0, 0);
        compare_model("slow_dump");
        tx_delay = 1;

        // Reset in the middle of a load, then an empty load
        wr_base = wr_q.size();
        tx_base = tx_q.size();
        send_byte(8'h4C);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        check_outputs_zero("mid_load_reset");
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        check("mid_load_reset no_write", 32'(wr_q.size() - wr_base), 32'd0);
        check("mid_load_reset no_tx", 32'(tx_q.size() - tx_base), 32'd0);
        repeat (2) @(negedge i_clk);
        run_txn(8'h4C, 0, 1'b0, 0, 1'b0);
        build_exp(8'h4C, 0, 1'b0, 0);
        compare_model("load_after_reset");

        // Randomized commands against the transaction model
        for (int t = 0; t < 10; t++) begin
            logic [7:0] cmd;
            int n, run_len;
            bit halt_pre, stray;
            case ($urandom_range(0, 4))
                0: cmd = 8'h4C;
                1: cmd = 8'h52;
                2: cmd = 8'h53;
                3: cmd = 8'h44;
                default: begin
                    cmd = 8'($urandom());
                    while (cmd == 8'h4C || cmd == 8'h52 || cmd == 8'h53 || cmd == 8'h44)
                        cmd = 8'($urandom());
                end
            endcase
            n        = $urandom_range(0, 3);
            run_len  = $urandom_range(1, 15);
            halt_pre = ($urandom_range(0, 3) == 0);
            stray    = (cmd == 8'h52 || cmd == 8'h53 || cmd == 8'h44);
            tx_delay = $urandom_range(0, 3);
            pc_val   = $urandom();
            for (int i = 0; i < 32; i++) begin
                reg_arr[i] = $urandom();
                mem_arr[i] = $urandom();
            end
            for (int i = 0; i < 4; i++) ld_words[i] = $urandom();
            run_txn(cmd, n, halt_pre, run_len, stray);
            build_exp(cmd, n, halt_pre, run_len);
            compare_model($sformatf("rand%0d cmd %h", t, cmd));
        end

        check("tx_protocol_total", 32'(proto_err), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
